// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and defaults for the packet FIFO.
// A memory word is laid out as {last, data}, with last in the MSB.
package sync_fifo_pkg;
  localparam int DEF_DATA_WIDTH   = 64;
  localparam int DEF_ADDR_WIDTH   = 3;
  localparam int DEF_FIFO_DEPTH   = 1 << DEF_ADDR_WIDTH;
  localparam int DEF_AFULL_LEVEL  = DEF_FIFO_DEPTH - 2;
  localparam int DEF_AEMPTY_LEVEL = 1;

  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction

  function automatic int mem_w(input int dw);
    return dw + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port register array: synchronous write, combinational read.
module sync_fifo_ram #(
  parameter int WIDTH = 65,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo_pkt.sv
// Packet-aware single-clock FIFO with frame commit/drop and status flags.
// Define SYNC_FIFO_PKT_FWFT_EN for first-word-fall-through reads.
module sync_fifo_pkt
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH   = 1 << ADDR_WIDTH,
  parameter int AFULL_LEVEL  = FIFO_DEPTH - 2,
  parameter int AEMPTY_LEVEL = DEF_AEMPTY_LEVEL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  input  logic                  wr_drop,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  pkt_avail,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int PW = ptr_w(ADDR_WIDTH);
  localparam int MW = mem_w(DATA_WIDTH);
  localparam logic [PW-1:0] DEPTH_P  = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] AFULL_P  = PW'(AFULL_LEVEL);
  localparam logic [PW-1:0] AEMPTY_P = PW'(AEMPTY_LEVEL);

  logic [PW-1:0]         r_wr_ptr_tmp, r_wr_ptr_cmt, r_rd_ptr, r_pkt_cnt;
  logic                  r_err, r_ovf, r_udf, r_rd_valid, r_rd_last;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [PW-1:0]         w_used, w_stored, w_level;
  logic [MW-1:0]         w_rd_word;
  logic                  w_full, w_empty, w_wr_acc, w_commit;
  logic                  w_load, w_pop, w_pop_last, w_udf_ev, w_rd_valid_nxt;

  assign w_used   = r_wr_ptr_tmp - r_rd_ptr;
  assign w_stored = r_wr_ptr_cmt - r_rd_ptr;
  assign w_full   = (w_used == DEPTH_P);
  assign w_wr_acc = wr_en && !w_full && !wr_drop;
  assign w_commit = w_wr_acc && wr_last && !r_err;

`ifdef SYNC_FIFO_PKT_FWFT_EN
  // Output register holds the head word; RAM refills it whenever it empties or pops.
  assign w_level        = w_stored + PW'(r_rd_valid);
  assign w_empty        = !r_rd_valid;
  assign w_pop          = rd_en && r_rd_valid;
  assign w_load         = (w_stored != '0) && (!r_rd_valid || rd_en);
  assign w_pop_last     = w_pop && r_rd_last;
  assign w_udf_ev       = rd_en && !r_rd_valid;
  assign w_rd_valid_nxt = w_load || (r_rd_valid && !w_pop);
`else
  assign w_level        = w_stored;
  assign w_empty        = (w_stored == '0);
  assign w_pop          = rd_en && !w_empty;
  assign w_load         = w_pop;
  assign w_pop_last     = w_pop && w_rd_word[MW-1];
  assign w_udf_ev       = rd_en && w_empty;
  assign w_rd_valid_nxt = w_load;
`endif

  sync_fifo_ram #(.WIDTH(MW), .AW(ADDR_WIDTH)) u_ram (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr_tmp[ADDR_WIDTH-1:0]),
    .i_wdata ({wr_last, wr_data}),
    .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rdata (w_rd_word)
  );

  // An errored frame (word lost while full) is rewound at its last word, never committed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr_tmp <= '0;
      r_wr_ptr_cmt <= '0;
      r_err        <= 1'b0;
      r_ovf        <= 1'b0;
    end else if (wr_drop) begin
      r_wr_ptr_tmp <= r_wr_ptr_cmt;
      r_err        <= 1'b0;
    end else if (wr_en) begin
      if (w_full) r_ovf <= 1'b1;
      if (wr_last && (r_err || w_full)) begin
        r_wr_ptr_tmp <= r_wr_ptr_cmt;
        r_err        <= 1'b0;
      end else if (w_full) begin
        r_err <= 1'b1;
      end else begin
        r_wr_ptr_tmp <= r_wr_ptr_tmp + 1'b1;
        if (wr_last) r_wr_ptr_cmt <= r_wr_ptr_tmp + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_rd_data  <= '0;
      r_rd_last  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_udf      <= 1'b0;
      r_pkt_cnt  <= '0;
    end else begin
      if (w_load) begin
        r_rd_data <= w_rd_word[DATA_WIDTH-1:0];
        r_rd_last <= w_rd_word[MW-1];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
      r_rd_valid <= w_rd_valid_nxt;
      if (w_udf_ev) r_udf <= 1'b1;
      case ({w_commit, w_pop_last})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + 1'b1;
        2'b01:   r_pkt_cnt <= r_pkt_cnt - 1'b1;
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

  assign full         = w_full;
  assign almost_full  = (w_used >= AFULL_P);
  assign empty        = w_empty;
  assign almost_empty = (w_level <= AEMPTY_P);
  assign level        = w_level;
  assign pkt_avail    = (r_pkt_cnt != '0);
  assign overflow     = r_ovf;
  assign underflow    = r_udf;
  assign rd_data      = r_rd_data;
  assign rd_last      = r_rd_last;
  assign rd_valid     = r_rd_valid;
endmodule

// File: tb/tb_sync_fifo_pkt.sv
// Self-checking bench for sync_fifo_pkt (DEPTH=8, DATA_WIDTH=64).
module tb_sync_fifo_pkt;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, wr_last = 1'b0, wr_drop = 1'b0, rd_en = 1'b0;
  logic [63:0] wr_data = '0;
  logic        full, almost_full, rd_last, rd_valid, empty, almost_empty;
  logic        pkt_avail, overflow, underflow;
  logic [63:0] rd_data;
  logic [3:0]  level;

  int n_chk = 0;
  int n_pass = 0;
  logic [64:0] sb[$];

  sync_fifo_pkt dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .wr_drop(wr_drop), .full(full), .almost_full(almost_full), .rd_en(rd_en),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .empty(empty),
    .almost_empty(almost_empty), .level(level), .pkt_avail(pkt_avail),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc();
    logic [64:0] e;
    @(posedge clk); #1;
`ifndef SYNC_FIFO_PKT_FWFT_EN
    if (rd_valid) begin
      if (sb.size() == 0) chk("rd_valid_unexpected", {63'd0, rd_valid}, 64'd0);
      else begin
        e = sb.pop_front();
        chk("rd_data", rd_data, e[63:0]);
        chk("rd_last", {63'd0, rd_last}, {63'd0, e[64]});
      end
    end
`endif
  endtask

  task automatic drive(input logic we, input logic [63:0] d, input logic wl,
                       input logic re, input logic push);
    wr_en = we; wr_data = d; wr_last = wl; wr_drop = 1'b0; rd_en = re;
    if (push) sb.push_back({wl, d});
  endtask

  task automatic do_reset();
    wr_en = 1'b0; wr_last = 1'b0; wr_drop = 1'b0; rd_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic drain();
    drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) break;
      cyc();
    end
    rd_en = 1'b0;
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  // in = {we, wl, drop, re, push}; ex = {empty, pkt_avail, rd_valid, full, afull, aempty, ovf, udf}
  typedef struct {
    logic [4:0]  in;
    logic [63:0] d;
    logic [3:0]  lvl;
    logic [7:0]  ex;
  } vec_t;
  vec_t tv[13];

  task automatic chk_status(input string tag, input logic [7:0] ex);
    chk({tag, "_empty"},     {63'd0, empty},        {63'd0, ex[7]});
    chk({tag, "_pkt_avail"}, {63'd0, pkt_avail},    {63'd0, ex[6]});
    chk({tag, "_rd_valid"},  {63'd0, rd_valid},     {63'd0, ex[5]});
    chk({tag, "_full"},      {63'd0, full},         {63'd0, ex[4]});
    chk({tag, "_afull"},     {63'd0, almost_full},  {63'd0, ex[3]});
    chk({tag, "_aempty"},    {63'd0, almost_empty}, {63'd0, ex[2]});
    chk({tag, "_overflow"},  {63'd0, overflow},     {63'd0, ex[1]});
    chk({tag, "_underflow"}, {63'd0, underflow},    {63'd0, ex[0]});
  endtask

  initial begin
    #2;
    chk_status("reset", 8'b10000100);
    chk("reset_level", {60'd0, level}, 64'd0);
    chk("reset_rd_data", rd_data, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

`ifdef SYNC_FIFO_PKT_FWFT_EN
    drive(1'b1, 64'hF00D, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("fwft_rd_valid", {63'd0, rd_valid}, 64'd1);
    chk("fwft_rd_data", rd_data, 64'hF00D);
    chk("fwft_level", {60'd0, level}, 64'd1);
    chk("fwft_empty", {63'd0, empty}, 64'd0);
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    chk("fwft_pop_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("fwft_pop_empty", {63'd0, empty}, 64'd1);
    chk("fwft_pop_pkt", {63'd0, pkt_avail}, 64'd0);
`else
    // Frame A with rd_en held, then partial frame B dropped, then frame C.
    tv[0]  = '{5'b10011, 64'hA1, 4'd0, 8'b10000101};
    tv[1]  = '{5'b10011, 64'hA2, 4'd0, 8'b10000101};
    tv[2]  = '{5'b11011, 64'hA3, 4'd3, 8'b01000001};
    tv[3]  = '{5'b00010, 64'h0,  4'd2, 8'b01100001};
    tv[4]  = '{5'b00010, 64'h0,  4'd1, 8'b01100101};
    tv[5]  = '{5'b00010, 64'h0,  4'd0, 8'b10100101};
    tv[6]  = '{5'b00010, 64'h0,  4'd0, 8'b10000101};
    tv[7]  = '{5'b10000, 64'hB1, 4'd0, 8'b10000101};
    tv[8]  = '{5'b10000, 64'hB2, 4'd0, 8'b10000101};
    tv[9]  = '{5'b11100, 64'hB3, 4'd0, 8'b10000101};
    tv[10] = '{5'b11001, 64'hC1, 4'd1, 8'b01000101};
    tv[11] = '{5'b00010, 64'h0,  4'd0, 8'b10100101};
    tv[12] = '{5'b00000, 64'h0,  4'd0, 8'b10000101};
    for (int i = 0; i < 13; i++) begin
      drive(tv[i].in[4], tv[i].d, tv[i].in[3], tv[i].in[1], tv[i].in[0]);
      wr_drop = tv[i].in[2];
      cyc();
      chk($sformatf("vec%0d_level", i), {60'd0, level}, {60'd0, tv[i].lvl});
      chk_status($sformatf("vec%0d", i), tv[i].ex);
    end
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

    // 10-word frame into 8 slots: overflow, auto-drop at last, then recovery.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 64'hD0 + 64'(i), (i == 9), 1'b0, 1'b0);
      cyc();
      if (i == 4) chk("ovf_afull_lo", {63'd0, almost_full}, 64'd0);
      if (i == 5) chk("ovf_afull_hi", {63'd0, almost_full}, 64'd1);
      if (i == 6) chk("ovf_full_lo", {63'd0, full}, 64'd0);
      if (i == 7) chk("ovf_full_hi", {63'd0, full}, 64'd1);
      if (i == 8) chk("ovf_flag", {63'd0, overflow}, 64'd1);
    end
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk("ovf_rewind_full", {63'd0, full}, 64'd0);
    chk("ovf_rewind_afull", {63'd0, almost_full}, 64'd0);
    chk("ovf_rewind_level", {60'd0, level}, 64'd0);
    chk("ovf_rewind_pkt", {63'd0, pkt_avail}, 64'd0);
    chk("ovf_sticky", {63'd0, overflow}, 64'd1);
    drive(1'b1, 64'hE0, 1'b0, 1'b0, 1'b1); cyc();
    drive(1'b1, 64'hE1, 1'b1, 1'b0, 1'b1); cyc();
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk("ovf_after_level", {60'd0, level}, 64'd2);
    chk("ovf_after_pkt", {63'd0, pkt_avail}, 64'd1);
    drain();

    // Fill with two frames, then stream write+read across the pointer wrap.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 64'h50 + 64'(i), (i % 4 == 3), 1'b0, 1'b1);
      cyc();
    end
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk("fill_full", {63'd0, full}, 64'd1);
    chk("fill_level", {60'd0, level}, 64'd8);
    chk("fill_pkt", {63'd0, pkt_avail}, 64'd1);
    drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    cyc();
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 64'h100 + 64'(k), (k % 4 == 3), 1'b1, 1'b1);
      cyc();
      chk($sformatf("stream%0d_full", k), {63'd0, full}, 64'd0);
    end
    drain();
    chk("stream_level", {60'd0, level}, 64'd0);
    chk("stream_pkt", {63'd0, pkt_avail}, 64'd0);
    chk("stream_ovf", {63'd0, overflow}, 64'd0);
    chk("stream_udf", {63'd0, underflow}, 64'd0);

    // Underflow stickiness, then async reset mid-frame.
    do_reset();
    drive(1'b1, 64'hC0, 1'b1, 1'b0, 1'b1); cyc();
    drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0); cyc();
    drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0); cyc();
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk("udf_set", {63'd0, underflow}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("udf_sticky%0d", i), {63'd0, underflow}, 64'd1);
    end
    drive(1'b1, 64'h71, 1'b0, 1'b0, 1'b0); cyc();
    drive(1'b1, 64'h72, 1'b0, 1'b0, 1'b0); cyc();
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk_status("midrst", 8'b10000100);
    chk("midrst_level", {60'd0, level}, 64'd0);
    chk("midrst_rd_data", rd_data, 64'd0);
    chk("midrst_rd_last", {63'd0, rd_last}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 64'h99, 1'b1, 1'b0, 1'b1); cyc();
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk("postrst_level", {60'd0, level}, 64'd1);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
